// File: rtl/gen_writer_if.sv
// Nibble stream from the source plus the genome-memory write port.
// slave is the writer's view; master is the source/memory view.
interface gen_writer_if;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       nib_last;
  logic       nib_ready;
  logic [7:0] addr_gen;
  logic [3:0] din_gen;
  logic       we_gen;

  modport slave (
    input  nib_in, nib_valid, nib_last,
    output nib_ready, addr_gen, din_gen, we_gen
  );

  modport master (
    output nib_in, nib_valid, nib_last,
    input  nib_ready, addr_gen, din_gen, we_gen
  );
endinterface

// File: rtl/gen_writer.sv
// Loads a nibble sequence into genome memory, appending two TERM nibbles; writes land 1 cycle
// after the handshake; nib_ready drops outside LOAD and once capacity (DEPTH-2 data nibbles) is hit.
module gen_writer #(
  parameter logic [3:0] TERM  = 4'hF,
  parameter int         DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  gen_writer_if.slave  bus,
  output logic         done_gen,
  output logic [7:0]   wr_count,
  output logic         err_term,
  output logic         overflow
);

  localparam logic [7:0] CAP       = 8'(DEPTH - 2);
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, TERM1, TERM2, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [3:0] din_q, din_nxt;
  logic       we_q, we_nxt;
  logic       done_q, done_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic       err_q, err_nxt;
  logic       ovf_q, ovf_nxt;

  assign bus.nib_ready = (state == LOAD) && (cnt_q != CAP);
  assign bus.addr_gen  = addr_q;
  assign bus.din_gen   = din_q;
  assign bus.we_gen    = we_q;
  assign done_gen      = done_q;
  assign wr_count      = cnt_q;
  assign err_term      = err_q;
  assign overflow      = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    addr_nxt  = addr_q;
    din_nxt   = din_q;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    ovf_nxt   = ovf_q;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_nxt   = 8'd0;
          addr_nxt  = 8'd0;
          cnt_nxt   = 8'd0;
          err_nxt   = 1'b0;
          ovf_nxt   = 1'b0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == CAP) begin
          ovf_nxt   = 1'b1;
          state_nxt = TERM1;
        end else if (bus.nib_valid) begin
          // A TERM-valued data nibble would fake an end marker, so it is dropped
          if (bus.nib_in != TERM) begin
            we_nxt   = 1'b1;
            din_nxt  = bus.nib_in;
            addr_nxt = ptr;
            ptr_nxt  = ptr + 8'd1;
            cnt_nxt  = cnt_q + 8'd1;
          end else begin
            err_nxt = 1'b1;
          end
          if (bus.nib_last) state_nxt = TERM1;
        end
      end
      TERM1, TERM2: begin
        we_nxt   = 1'b1;
        din_nxt  = TERM;
        addr_nxt = ptr;
        // Saturate so the final terminator at the top address never wraps the pointer
        if (ptr != LAST_ADDR) ptr_nxt = ptr + 8'd1;
        done_nxt  = (state == TERM2);
        state_nxt = (state == TERM1) ? TERM2 : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= 8'd0;
      addr_q <= 8'd0;
      din_q  <= 4'd0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 8'd0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      addr_q <= addr_nxt;
      din_q  <= din_nxt;
      we_q   <= we_nxt;
      done_q <= done_nxt;
      cnt_q  <= cnt_nxt;
      err_q  <= err_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_gen_writer.sv
// Directed bench for gen_writer: stimulus pushes expected memory writes into a queue,
// an independent monitor pops and compares every observed write.
module tb_gen_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       done_gen;
  logic [7:0] wr_count;
  logic       err_term;
  logic       overflow;

  gen_writer_if bus ();

  gen_writer #(.TERM(4'hF), .DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .done_gen (done_gen),
    .wr_count (wr_count),
    .err_term (err_term),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int a, input int d);
    exp_q.push_back({8'(a), 4'(d)});
  endtask

  // Monitor: every write seen on the memory port must match the head of the queue
  always @(negedge clk) begin
    if (rst && bus.we_gen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d din=%h expected no write",
                 bus.addr_gen, bus.din_gen);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({bus.addr_gen, bus.din_gen} != e) begin
          bad++;
          $display("FAIL write: got addr=%0d din=%h expected addr=%0d din=%h",
                   bus.addr_gen, bus.din_gen, e[11:4], e[3:0]);
        end
      end
    end
    if (rst && done_gen) done_cnt++;
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [3:0] n, input logic last, input int budget, output bit ok);
    bus.nib_in = n; bus.nib_valid = 1'b1; bus.nib_last = last;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); ok = bus.nib_ready;
      @(posedge clk); #1;
    end
    bus.nib_valid = 1'b0; bus.nib_last = 1'b0;
  endtask

  task automatic send_ok(input logic [3:0] n, input logic last);
    bit ok;
    send(n, last, 20, ok);
    chk("handshake", int'(ok), 1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int acc;
    bit ok;
    bus.nib_in = 4'd0; bus.nib_valid = 1'b0; bus.nib_last = 1'b0;

    // Reset values
    #12;
    chk("rst_addr", bus.addr_gen, 0);
    chk("rst_din", bus.din_gen, 0);
    chk("rst_we", bus.we_gen, 0);
    chk("rst_done", done_gen, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_err", err_term, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", bus.nib_ready, 0);
    @(negedge clk); rst = 1'b1;

    // Basic sequence 1,2,3
    d0 = done_cnt;
    expect_wr(0, 1); expect_wr(1, 2); expect_wr(2, 3); expect_wr(3, 15); expect_wr(4, 15);
    do_start();
    send_ok(4'd1, 1'b0); send_ok(4'd2, 1'b0); send_ok(4'd3, 1'b1);
    wait_done(d0);
    chk("t1_cnt", wr_count, 3);
    chk("t1_err", err_term, 0);
    chk("t1_ovf", overflow, 0);

    // TERM-valued data nibble is dropped
    d0 = done_cnt;
    expect_wr(0, 4); expect_wr(1, 5); expect_wr(2, 15); expect_wr(3, 15);
    do_start();
    send_ok(4'd4, 1'b0); send_ok(4'hF, 1'b0); send_ok(4'd5, 1'b1);
    wait_done(d0);
    chk("t2_cnt", wr_count, 2);
    chk("t2_err", err_term, 1);

    // Overflow: 300 offered, 254 accepted, terminators at 254 and 255
    d0 = done_cnt;
    for (int i = 0; i < 254; i++) expect_wr(i, i % 15);
    expect_wr(254, 15); expect_wr(255, 15);
    do_start();
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      send(4'(i % 15), 1'b0, 5, ok);
      if (!ok) break;
      acc++;
    end
    chk("t3_accepted", acc, 254);
    wait_done(d0);
    chk("t3_cnt", wr_count, 254);
    chk("t3_ovf", overflow, 1);
    chk("t3_err", err_term, 0);
    @(negedge clk);
    chk("t3_ready_low", bus.nib_ready, 0);

    // valid toggling every other cycle
    d0 = done_cnt;
    expect_wr(0, 7); expect_wr(1, 8); expect_wr(2, 9); expect_wr(3, 10);
    expect_wr(4, 15); expect_wr(5, 15);
    do_start();
    send_ok(4'd7, 1'b0); @(posedge clk); #1;
    send_ok(4'd8, 1'b0); @(posedge clk); #1;
    send_ok(4'd9, 1'b0); @(posedge clk); #1;
    send_ok(4'hA, 1'b1);
    wait_done(d0);
    chk("t4_cnt", wr_count, 4);
    chk("t4_ovf_cleared", overflow, 0);

    // Reset mid-load: no terminators, no done
    d0 = done_cnt;
    expect_wr(0, 1); expect_wr(1, 2);
    do_start();
    send_ok(4'd1, 1'b0); send_ok(4'd2, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk("t5_we", bus.we_gen, 0);
    chk("t5_addr", bus.addr_gen, 0);
    chk("t5_din", bus.din_gen, 0);
    chk("t5_cnt", wr_count, 0);
    chk("t5_ready", bus.nib_ready, 0);
    @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_queue", exp_q.size(), 0);
    chk("t5_no_done", done_cnt - d0, 0);
    // Start on the very first edge after release
    rst = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d0 = done_cnt;
    expect_wr(0, 11); expect_wr(1, 12); expect_wr(2, 15); expect_wr(3, 15);
    send_ok(4'hB, 1'b0); send_ok(4'hC, 1'b1);
    wait_done(d0);
    chk("t5_reload_cnt", wr_count, 2);

    // start during LOAD and during DONE is ignored
    d0 = done_cnt;
    expect_wr(0, 6); expect_wr(1, 13); expect_wr(2, 15); expect_wr(3, 15);
    do_start();
    send_ok(4'd6, 1'b0);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    send_ok(4'hD, 1'b1);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t6_idle_after_done", bus.nib_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_done_pulses", done_cnt - d0, 1);
    chk("t6_queue", exp_q.size(), 0);
    chk("t6_cnt", wr_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
